// File: rtl/uart_pkg.sv
// Shared UART constants for the peripheral register file and the RX buffer.
package uart_pkg;

  // Default sizing of the receive buffer.
  localparam int UART_RX_DEPTH = 16;
  localparam int UART_RX_AW    = 4;
  localparam int UART_BYTE_W   = 8;

  // Register offsets. The peripheral decodes these to produce pop (read of RXD)
  // and clr_ovr (write of CON).
  localparam logic [7:0] UART_TXD_OFS = 8'h18;
  localparam logic [7:0] UART_RXD_OFS = 8'h1C;
  localparam logic [7:0] UART_CON_OFS = 8'h20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single-bit level from another clock domain.
// The reset value is a parameter so that idle-high sources can reset high
// and produce no false edge when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic cpu_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  // Two flops in series: the first may go metastable, the second settles it.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the CPU register file.
// Rising edges of the synchronised rx_status flag push rx_data into a
// show-ahead FIFO; the CPU sees the head byte, occupancy, a sticky overrun
// flag and a registered interrupt request.
//
// Transfer rules: a push is offered for exactly one cycle per rx_status edge
// and has no backpressure -- it is accepted when the FIFO is not full, or when
// full with a pop in the same cycle; otherwise the byte is dropped and overrun
// is set. A pop is a one-cycle request that is honoured only when the FIFO is
// non-empty and is silently ignored when empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int AW    = UART_RX_AW
) (
  input  logic                   cpu_clk,
  input  logic                   reset,
  input  logic                   rx_status,
  input  logic [UART_BYTE_W-1:0] rx_data,
  input  logic                   pop,
  input  logic                   clr_ovr,
  input  logic                   irq_en,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            count,
  output logic                   overrun,
  output logic                   irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic                   s2;
  logic                   s2d;
  logic                   push;
  logic                   do_push;
  logic                   do_pop;
  logic                   drop;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [UART_BYTE_W-1:0] mem [DEPTH];

  // Synchronise the frame-done flag; resets high so an idle-high line is quiet.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_status_sync (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .d       (rx_status),
    .q       (s2)
  );

  // Delayed copy of the synchronised flag for rising-edge detection.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) s2d <= 1'b1;
    else        s2d <= s2;
  end

  // Derive the effective push/pop/drop for this cycle.
  always_comb begin
    push    = s2 & ~s2d;
    do_pop  = pop & ~empty;
    // When full, empty is low, so a pop here is always effective and frees a slot.
    do_push = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  // Write port; memory contents are deliberately not reset.
  always_ff @(posedge cpu_clk) begin
    if (do_push) mem[wptr] <= rx_data;
  end

  // Pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      // A drop in the same cycle as a clear must not be lost.
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  // Registered interrupt request, one cycle behind the empty flag.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= irq_en & ~empty;
  end

  // Status flags and show-ahead head byte, all from registered state.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_CNT);
    rd_data = empty ? '0 : mem[rptr];
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       cpu_clk;
  logic       reset;
  logic       rx_status;
  logic [7:0] rx_data;
  logic       pop;
  logic       clr_ovr;
  logic       irq_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  int checks;
  int failures;

  // Scoreboard: bytes expected to be in the FIFO, head first.
  logic [7:0] exp_q[$];
  logic       exp_ovr;

  uart_rx_fifo dut (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .rx_status (rx_status),
    .rx_data   (rx_data),
    .pop       (pop),
    .clr_ovr   (clr_ovr),
    .irq_en    (irq_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .irq       (irq)
  );

  // Clock: posedges at 5, 15, 25 ...
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // One receiver frame. Optional pop / clr_ovr land in the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic with_pop, input logic with_clr);
    rx_data   = b;
    rx_status = 1'b1;
    tick();
    tick();
    pop     = with_pop;
    clr_ovr = with_clr;
    tick();
    pop       = 1'b0;
    clr_ovr   = 1'b0;
    rx_status = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // A frame arriving, with an optional same-cycle pop and clear.
  task automatic model_frame(input logic [7:0] b, input logic with_pop, input logic with_clr);
    logic popped;
    logic accepted;
    popped   = with_pop && (exp_q.size() > 0);
    accepted = (exp_q.size() < DEPTH) || popped;
    if (popped) void'(exp_q.pop_front());
    if (accepted) exp_q.push_back(b);
    if (!accepted)     exp_ovr = 1'b1;
    else if (with_clr) exp_ovr = 1'b0;
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // Expected {count, empty, full, overrun, rd_data}.
  function automatic logic [15:0] exp_vec();
    logic [4:0] c;
    logic [7:0] h;
    c = 5'(exp_q.size());
    h = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
    return {c, exp_q.size() == 0, exp_q.size() == DEPTH, exp_ovr, h};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; rx_status = 1'b1; rx_data = 8'h00;
    pop = 1'b0; clr_ovr = 1'b0; irq_en = 1'b1;
    exp_q.delete(); exp_ovr = 1'b0;
    #12;
    checks++;
    if ({count, empty, full, overrun, rd_data, irq} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got cnt=%0d emp=%b full=%b ovr=%b rd=%h irq=%b, want cnt=0 emp=1 full=0 ovr=0 rd=00 irq=0",
               count, empty, full, overrun, rd_data, irq);
    end
    reset = 1'b1;
    repeat (5) tick();
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      failures++;
      $display("FAIL idle_high_after_reset: got cnt=%0d emp=%b, want cnt=0 emp=1", count, empty);
    end
    rx_status = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    rx_data   = 8'hA5;
    rx_status = 1'b1;
    tick();
    tick();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL single_latency_early: got empty=%b after 2 edges, want 1", empty);
    end
    tick();
    exp_q.push_back(8'hA5);
    checks++;
    if ({empty, rd_data, count, irq} !== {1'b0, 8'hA5, 5'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_push: got emp=%b rd=%h cnt=%0d irq=%b, want emp=0 rd=a5 cnt=1 irq=0",
               empty, rd_data, count, irq);
    end
    rx_status = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise: got irq=%b one cycle after empty fell, want 1", irq);
    end
    tick();
    tick();
    pop_one();
    model_pop();
    checks++;
    if ({empty, rd_data, count, irq} !== {1'b1, 8'h00, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL single_pop: got emp=%b rd=%h cnt=%0d irq=%b, want emp=1 rd=00 cnt=0 irq=1",
               empty, rd_data, count, irq);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall: got irq=%b one cycle after pop emptied fifo, want 0", irq);
    end
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      model_frame(8'(i), 1'b0, 1'b0);
    end
    send_frame(8'hFF, 1'b0, 1'b0);
    model_frame(8'hFF, 1'b0, 1'b0);
    checks++;
    if ({full, count, overrun} !== {1'b1, 5'd16, 1'b1}) begin
      failures++;
      $display("FAIL full_overrun: got full=%b cnt=%0d ovr=%b, want full=1 cnt=16 ovr=1", full, count, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin
        failures++;
        $display("FAIL drain_order[%0d]: got rd=%h, want %h", i, rd_data, 8'(i));
      end
      pop_one();
      model_pop();
    end
    checks++;
    if ({count, empty, full, overrun, rd_data} !== exp_vec()) begin
      failures++;
      $display("FAIL drained_state: got {cnt,emp,full,ovr,rd}=%h, want %h",
               {count, empty, full, overrun, rd_data}, exp_vec());
    end
  endtask

  task automatic test_clr_ovr();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      model_frame(8'(0), 1'b0, 1'b0);
      exp_q[exp_q.size()-1] = rx_data;
    end
    send_frame(8'hEE, 1'b0, 1'b1);
    model_frame(8'hEE, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL set_beats_clear: got ovr=%b, want 1", overrun);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL lone_clear: got ovr=%b, want 0", overrun);
    end
  endtask

  task automatic test_full_pop_push();
    send_frame(8'h55, 1'b1, 1'b0);
    model_frame(8'h55, 1'b1, 1'b0);
    checks++;
    if ({count, overrun, full} !== {5'd16, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL full_pop_push: got cnt=%0d ovr=%b full=%b, want cnt=16 ovr=0 full=1", count, overrun, full);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== exp_q[0]) begin
        failures++;
        $display("FAIL full_pop_push_drain[%0d]: got rd=%h, want %h", i, rd_data, exp_q[0]);
      end
      if (i == 15) begin
        checks++;
        if (rd_data !== 8'h55) begin
          failures++;
          $display("FAIL last_byte: got rd=%h, want 55", rd_data);
        end
      end
      pop_one();
      model_pop();
    end
  endtask

  task automatic test_empty_pop_push();
    send_frame(8'h3C, 1'b1, 1'b0);
    model_frame(8'h3C, 1'b1, 1'b0);
    checks++;
    if ({count, rd_data, empty} !== {5'd1, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL empty_pop_push: got cnt=%0d rd=%h emp=%b, want cnt=1 rd=3c emp=0", count, rd_data, empty);
    end
    pop_one();
    model_pop();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      send_frame(8'(8'h80 + i), 1'b0, 1'b0);
      model_frame(8'(8'h80 + i), 1'b0, 1'b0);
    end
    checks++;
    if ({count, irq} !== {5'd5, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_fill: got cnt=%0d irq=%b, want cnt=5 irq=1", count, irq);
    end
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    checks++;
    if ({count, empty, irq, rd_data} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL async_reset: got cnt=%0d emp=%b irq=%b rd=%h, want cnt=0 emp=1 irq=0 rd=00",
               count, empty, irq, rd_data);
    end
    rx_status = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    repeat (5) tick();
    checks++;
    if ({count, empty, irq} !== {5'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL no_spurious_push: got cnt=%0d emp=%b irq=%b, want cnt=0 emp=1 irq=0", count, empty, irq);
    end
    rx_status = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    int op;
    logic [7:0] b;
    logic wp;
    logic wc;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op < 5) begin
        b  = 8'($urandom_range(0, 255));
        wp = ($urandom_range(0, 3) == 0);
        wc = ($urandom_range(0, 3) == 0);
        send_frame(b, wp, wc);
        model_frame(b, wp, wc);
      end else if (op < 9) begin
        pop_one();
        model_pop();
        tick();
      end else begin
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        exp_ovr = 1'b0;
      end
      checks++;
      if ({count, empty, full, overrun, rd_data} !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got {cnt,emp,full,ovr,rd}=%h, want %h",
                 n, {count, empty, full, overrun, rd_data}, exp_vec());
      end
      checks++;
      if (irq !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL random_irq[%0d]: got irq=%b, want %b", n, irq, exp_q.size() != 0);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_full_overrun();
    test_clr_ovr();
    test_full_pop_push();
    test_empty_pop_push();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver (baud-clock domain) and the memory-mapped peripheral register file on `cpu_clk`. It synchronises the receiver's `rx_status` completion flag and detects its rising edges. Each completed frame's byte is pushed into a small show-ahead FIFO. The FIFO exposes head data, occupancy, a sticky overrun flag and an interrupt request, so software reading the RX data register no longer loses bytes that arrive faster than it polls.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, at least 2.
- `AW`, 4, pointer width, log2(`DEPTH`).
- `cpu_clk`  in  1  processor clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_status`  in  1  receiver frame-done flag from the baud-clock domain; a rising edge means `rx_data` holds a new byte.
- `rx_data`  in  8  receiver byte; stable for at least 4 `cpu_clk` cycles after `rx_status` rises.
- `pop`  in  1  consume the head entry; the peripheral asserts it for one cycle on a read of the RX data register.
- `clr_ovr`  in  1  clear `overrun`; the peripheral asserts it on a write to the UART control register.
- `irq_en`  in  1  RX interrupt enable.
- `rd_data`  out  8  head byte (show-ahead); 0 when `empty`.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  AW+1  occupancy, 0..`DEPTH`.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `irq`  out  1  registered copy of `irq_en & ~empty`.

## Operation
- Synchroniser: `s1 <= rx_status`, `s2 <= s1`, `s2d <= s2`.
  - All three flops reset to 1, so an idle-high receiver does not cause a spurious push after reset.
  - `push = s2 & ~s2d`: exactly one cycle per rising edge of `rx_status`.
- Push:
  - If not full, or full with `pop` in the same cycle: write `rx_data` into `mem[wptr]` and increment `wptr`, wrapping modulo `DEPTH`.
  - If full without `pop`: drop the byte and set `overrun`. Memory and pointers are unchanged.
- Pop:
  - If not empty: increment `rptr`, wrapping.
  - If empty: ignore it; no pointer change and no error flag.
- Simultaneous push and pop:
  - Non-empty: both take effect and `count` is unchanged.
  - Empty: the push is accepted, the pop is ignored, and `count` becomes 1.
- `count`: +1 on an accepted push only; -1 on an effective pop only; otherwise held. `full = (count == DEPTH)`; `empty = (count == 0)`.
- `overrun`: set by a dropped push, cleared by `clr_ovr`. If both happen in the same cycle, set wins.
- `rd_data = empty ? 8'h00 : mem[rptr]` (combinational from registered state).
- Reset values:
  - `wptr`, `rptr`, `count` = 0; `overrun` = 0; `irq` = 0.
  - `empty` = 1; `full` = 0; `rd_data` = 0.
  - Memory contents are not reset.
- Reset asserted mid-frame or mid-operation discards every entry immediately.

## Timing
- Push latency, with `rx_status` first sampled high at edge E0:
  - `s1` is 1 after E0; `s2` is 1 after E1.
  - `push` is high in the cycle between E1 and E2; the write happens at E2.
  - `empty` falls and `rd_data` is valid after E2.
- `rx_data` is sampled at E2. The stability requirement (at least 4 cycles) covers this.
- Pop: sampled at edge E. `rd_data`, `count` and `empty` update after E. Back-to-back pops every cycle are allowed.
- `irq` lags `empty` by one cycle: it rises one cycle after the first accepted push and falls one cycle after the pop that empties the FIFO.
- `rx_status` pulses must be high and low for at least 2 `cpu_clk` cycles each to be detected. At 9600 baud and a 50 MHz-class clock this is always met.

## Structure
- Shared package `uart_pkg`:
  - `UART_RX_DEPTH` = 16, `UART_RX_AW` = 4, `UART_BYTE_W` = 8.
  - The register offsets `UART_TXD_OFS` 8'h18, `UART_RXD_OFS` 8'h1C and `UART_CON_OFS` 8'h20, which the peripheral uses to generate `pop` and `clr_ovr`.
- One sub-module, `sync_2ff`: two-flop synchroniser with parameterised reset value. It is reused later for the TX busy flag.
- Memory is a plain register array; no vendor RAM.

## Test plan
- Reset, then receive a single frame with `rx_data` = 8'hA5 → `empty` falls exactly 3 edges after `rx_status` rises; `rd_data` = 8'hA5 and `count` = 1. A `pop` then gives `empty` = 1 and `rd_data` = 0.
- Push 16 bytes (8'h00..8'h0F), then a 17th byte 8'hFF → `full` = 1, `count` = 16, `overrun` = 1. Sixteen pops return 8'h00..8'h0F in order, and 8'hFF never appears.
- With the FIFO full, pop in the same cycle as a push of 8'h55 → `count` stays 16, `overrun` stays 0, and 8'h55 is the last byte read.
- With the FIFO empty, pop in the same cycle as a push of 8'h3C → `count` = 1 and `rd_data` = 8'h3C.
- `overrun` set, with `clr_ovr` and a dropped push in the same cycle → `overrun` remains 1. A lone `clr_ovr` next cycle → 0.
- `irq_en` = 1: `irq` rises 1 cycle after `empty` falls. Async `reset` pulse with 5 entries stored → `count` = 0, `empty` = 1 and `irq` = 0 immediately. The idle-high `rx_status` after reset produces no push.
